led_mode_ctrl: RTL and testbench

Front-end controller for the 4-LED pattern engine. It synchronises and debounces the three push keys and turns each key press into a command: select pattern, change speed, or pause/resume. It owns the run/pause/idle state machine and generates the step tick whose period depends on the selected speed. The pattern engine consumes pattern, load and tick and never sees raw keys.

---
 rtl/led_pkg.sv | 33 +++
 rtl/key_debounce.sv | 53 +++++
 rtl/led_mode_ctrl.sv | 104 ++++++++++
 tb/tb_led_mode_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared encodings for the LED mode controller
package led_pkg;

    typedef enum logic [1:0] {
        PAT_NONE  = 2'd0,
        PAT_LEFT  = 2'd1,
        PAT_RIGHT = 2'd2,
        PAT_BLINK = 2'd3
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // Value the pattern engine reloads on a load strobe (cleared instead when pattern is NONE)
    localparam logic [3:0] SEED = 4'b0001;

    localparam int K_NEXT  = 0;
    localparam int K_SPEED = 1;
    localparam int K_PAUSE = 2;

    // Cycle LEFT -> RIGHT -> BLINK -> LEFT; NONE also enters at LEFT
    function automatic pattern_e next_pattern(input pattern_e p);
        case (p)
            PAT_LEFT:  return PAT_RIGHT;
            PAT_RIGHT: return PAT_BLINK;
            default:   return PAT_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronise and debounce one active-low key, pulse on press
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_i,
    output logic press_o
);

    localparam int unsigned    CW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // Two-flop synchroniser; released (1) out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync2_q == sync1_q ? sync2_q : sync1_q;
        end
    end

    // Accept a level change only after it has been stable long enough; pulse on the falling edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                press_q <= ~sync2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - key front-end, run/pause FSM and step tick generator
module led_mode_ctrl
    import led_pkg::*;
#(
    parameter int unsigned TICK_BASE    = 25_000_000,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] key,
    output logic [1:0] pattern,
    output logic [1:0] speed,
    output logic       tick,
    output logic       load,
    output logic       running
);

    localparam int unsigned CW = $clog2(TICK_BASE);

    logic [2:0]    press;
    logic          cmd_next;
    logic          cmd_speed;
    logic          cmd_pause;
    logic [CW-1:0] last_cnt;

    state_e        state_q;
    pattern_e      pattern_q;
    logic [1:0]    speed_q;
    logic          tick_q;
    logic          load_q;
    logic          running_q;
    logic [CW-1:0] cnt_q;

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
        ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .key_i   (key[i]),
            .press_o (press[i])
        );
    end

    // Fixed priority NEXT > SPEED > PAUSE; losers in the same cycle are dropped
    always_comb begin
        cmd_next  = press[K_NEXT];
        cmd_speed = press[K_SPEED] & ~press[K_NEXT];
        cmd_pause = press[K_PAUSE] & ~press[K_SPEED] & ~press[K_NEXT];
    end

    // Terminal count for the current speed; speed changes clear the counter so this is never stale
    always_comb begin
        last_cnt = CW'((TICK_BASE >> speed_q) - 1);
    end

    // Mode FSM, command handling and tick counter; commands pre-empt a tick due in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pattern_q <= PAT_NONE;
            speed_q   <= 2'd0;
            tick_q    <= 1'b0;
            load_q    <= 1'b0;
            running_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            tick_q <= 1'b0;
            load_q <= 1'b0;
            if (cmd_next) begin
                pattern_q <= (state_q == ST_IDLE) ? PAT_LEFT : next_pattern(pattern_q);
                state_q   <= ST_RUN;
                running_q <= 1'b1;
                load_q    <= 1'b1;
                cnt_q     <= '0;
            end else if (cmd_speed) begin
                speed_q <= speed_q + 2'd1;
                cnt_q   <= '0;
            end else if (cmd_pause) begin
                if (state_q == ST_RUN) begin
                    state_q   <= ST_PAUSE;
                    running_q <= 1'b0;
                end else if (state_q == ST_PAUSE) begin
                    state_q   <= ST_RUN;
                    running_q <= 1'b1;
                end
            end else if (state_q == ST_RUN) begin
                if (cnt_q == last_cnt) begin
                    tick_q <= 1'b1;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign pattern = pattern_q;
    assign speed   = speed_q;
    assign tick    = tick_q;
    assign load    = load_q;
    assign running = running_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// tb/tb_led_mode_ctrl.sv - scoreboard bench for led_mode_ctrl
module tb_led_mode_ctrl;

    localparam int TB  = 16;
    localparam int DB  = 4;
    localparam int LAT = DB + 3;

    localparam int K_CHG  = 0;
    localparam int K_LOAD = 1;
    localparam int K_TICK = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] key = 3'b111;
    logic [1:0] pattern;
    logic [1:0] speed;
    logic       tick;
    logic       load;
    logic       running;

    led_mode_ctrl #(
        .TICK_BASE    (TB),
        .DEBOUNCE_CYC (DB)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key     (key),
        .pattern (pattern),
        .speed   (speed),
        .tick    (tick),
        .load    (load),
        .running (running)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        int         at;
        logic [1:0] pat;
        logic [1:0] spd;
        logic       run;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    logic mon_en = 1'b0;

    logic [4:0] mon_snap;
    logic [4:0] mon_prev;
    logic       mon_first = 1'b1;
    int         mon_kind;
    ev_t        mon_e;

    always @(negedge clk) begin
        #1;
        if (mon_en) begin
            mon_snap = {pattern, speed, running};
            if (mon_first || load || tick || mon_snap != mon_prev) begin
                mon_kind = {30'd0, tick, load};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL event: unexpected kind=%0d cyc=%0d pat=%0d spd=%0d run=%0d, required no event",
                             mon_kind, cyc, pattern, speed, running);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.kind != mon_kind || (mon_e.at >= 0 && mon_e.at != cyc) ||
                        mon_e.pat != pattern || mon_e.spd != speed || mon_e.run != running) begin
                        errors++;
                        $display("FAIL event: got kind=%0d cyc=%0d pat=%0d spd=%0d run=%0d, required kind=%0d cyc=%0d pat=%0d spd=%0d run=%0d",
                                 mon_kind, cyc, pattern, speed, running,
                                 mon_e.kind, mon_e.at, mon_e.pat, mon_e.spd, mon_e.run);
                    end
                end
                mon_first = 1'b0;
                mon_prev  = mon_snap;
            end
        end
    end

    // Reference state: 0 idle, 1 run, 2 pause
    logic [1:0] m_pat = 2'd0;
    logic [1:0] m_spd = 2'd0;
    int         m_st = 0;
    int         next_tick = 0;
    int         held = 0;

    function automatic int period();
        return TB >> m_spd;
    endfunction

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        e.pat  = m_pat;
        e.spd  = m_spd;
        e.run  = (m_st == 1);
        exp_q.push_back(e);
    endtask

    task automatic sched(input int limit);
        while (m_st == 1 && next_tick < limit) begin
            push(K_TICK, next_tick);
            next_tick += period();
        end
    endtask

    task automatic wait_cyc(input int n);
        sched(cyc + n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [2:0] mask);
        int c;
        c = cyc + LAT;
        sched(c);
        if (mask[0]) begin
            m_pat = (m_st == 0 || m_pat == 2'd3) ? 2'd1 : m_pat + 2'd1;
            m_st = 1;
            next_tick = c + period();
            push(K_LOAD, c);
        end else if (mask[1]) begin
            m_spd = m_spd + 2'd1;
            next_tick = c + period();
            held = 0;
            push(K_CHG, c);
        end else if (mask[2]) begin
            if (m_st == 1) begin
                held = period() - (next_tick - c + 1);
                m_st = 2;
                push(K_CHG, c);
            end else if (m_st == 2) begin
                m_st = 1;
                next_tick = c + period() - held;
                push(K_CHG, c);
            end
        end
        key = ~mask;
        wait_cyc(10);
        key = 3'b111;
        wait_cyc(10);
    endtask

    initial begin
        int w;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push(K_CHG, -1);
        mon_en = 1'b1;

        // Idle with keys released
        wait_cyc(200);

        // Short glitch on NEXT, then a real press
        key = 3'b110;
        wait_cyc(3);
        key = 3'b111;
        wait_cyc(10);
        press(3'b001);
        wait_cyc(40);

        // Pattern 2, 3, back to 1
        for (int i = 0; i < 3; i++) begin
            press(3'b001);
            wait_cyc(5);
        end

        // Speed 1, 2, 3, 0
        press(3'b010);
        wait_cyc(20);
        for (int i = 0; i < 3; i++) press(3'b010);
        wait_cyc(40);

        // Pause with the counter at 5, hold, resume
        w = ((next_tick - cyc - 17) % TB + TB) % TB;
        wait_cyc(w);
        press(3'b100);
        wait_cyc(50);
        press(3'b100);
        wait_cyc(30);

        // NEXT and PAUSE pressed together
        press(3'b101);
        wait_cyc(7);

        // Asynchronous reset mid-count
        rst_n = 1'b0;
        m_pat = 2'd0;
        m_spd = 2'd0;
        m_st  = 0;
        push(K_CHG, cyc);
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(5);

        // PAUSE ignored in idle; first NEXT after reset needs a full debounce
        press(3'b100);
        press(3'b001);
        wait_cyc(30);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue: %0d expected events never seen, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
